mem_block_copier: RTL



---
 rtl/mem_block_copier_pkg.sv | 20 ++
 rtl/mem_block_copier.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_block_copier_pkg.sv
// rtl/mem_block_copier_pkg.sv - shared bus command codes, copier state enum and default widths
package mem_block_copier_pkg;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 16;

    // Memory-bus commands, shared with the CPU and the memory/I-O decode
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_DONE
    } copier_state_t;

endpackage

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - memory-bus initiator copying a block of words between address ranges
//
// Second bus master beside the CPU; an external arbiter muxes its bus outputs while busy=1.
// Every word costs RD_ADDR, RD_DATA, WR (3 cycles); DONE adds one cycle, so the latency is 3*len+1.
// Optional macro MEMCPY_FILL_EN adds fill/fill_value: a fill writes fill_value to
// dst..dst+len-1 at one word per cycle and issues no reads.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   start                 request a copy (sampled only in IDLE)
//   src_addr, dst_addr    first source / destination word address
//   len                   word count, 0 = no-op (done pulse only)
//   fill, fill_value      fill-mode request and pattern (MEMCPY_FILL_EN only)
//   busy                  high whenever the FSM is not in IDLE
//   done                  one-cycle completion pulse
//   mem_cmd, mem_addr     bus command (MNONE/MREAD/MWRITE) and address
//   write_data            data driven during MWRITE
//   read_data             bus read data, valid the cycle after MREAD is first presented
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef MEMCPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    copier_state_t     state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  count;
`ifdef MEMCPY_FILL_EN
    logic              fill_mode;
`endif

    // Bus outputs are registered alongside the state transition, so each
    // output already holds the value belonging to the state being entered.
    // write_data doubles as the captured-word register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            write_data <= '0;
            src        <= '0;
            dst        <= '0;
            count      <= '0;
`ifdef MEMCPY_FILL_EN
            fill_mode  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_cmd <= MNONE;
                    if (start) begin
                        busy <= 1'b1;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            src   <= src_addr;
                            dst   <= dst_addr;
                            count <= len;
`ifdef MEMCPY_FILL_EN
                            fill_mode <= fill;
                            if (fill) begin
                                state      <= ST_WR;
                                mem_cmd    <= MWRITE;
                                mem_addr   <= dst_addr;
                                write_data <= fill_value;
                            end else
`endif
                            begin
                                state    <= ST_RD_ADDR;
                                mem_cmd  <= MREAD;
                                mem_addr <= src_addr;
                            end
                        end
                    end
                end

                // Command and address are held so the RAM read enable stays on
                // through the registered-read cycle.
                ST_RD_ADDR: begin
                    state <= ST_RD_DATA;
                end

                ST_RD_DATA: begin
                    state      <= ST_WR;
                    mem_cmd    <= MWRITE;
                    mem_addr   <= dst;
                    write_data <= read_data;
                end

                ST_WR: begin
                    src   <= src + ADDR_W'(1);
                    dst   <= dst + ADDR_W'(1);
                    count <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state   <= ST_DONE;
                        mem_cmd <= MNONE;
                        done    <= 1'b1;
                    end
`ifdef MEMCPY_FILL_EN
                    else if (fill_mode) begin
                        mem_addr <= dst + ADDR_W'(1);
                    end
`endif
                    else begin
                        state    <= ST_RD_ADDR;
                        mem_cmd  <= MREAD;
                        mem_addr <= src + ADDR_W'(1);
                    end
                end

                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_cmd <= MNONE;
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_cmd <= MNONE;
                end
            endcase
        end
    end

endmodule
